// File: rtl/bus_copier_if.sv
// bus_copier_if: command and shared-bus signals of the copy engine.
// Latency: none, wiring only.
// Backpressure: bus_gnt from the external arbiter is the only stall source.
// BUS_COPIER_CHECKSUM_EN adds the 32-bit sum signal to both modports.
interface bus_copier_if #(
   parameter int COUNT_W = 16
);
   // command side
   logic               start;
   logic [29:0]        src;
   logic [29:0]        dst;
   logic [COUNT_W-1:0] count;
   logic               busy;
   logic               done;
   // shared memory bus side
   logic               bus_req;
   logic               bus_gnt;
   logic [29:0]        bus_addr;
   logic [31:0]        bus_data_r;
   logic [31:0]        bus_data_w;
   logic [3:0]         bus_mask_w;
`ifdef BUS_COPIER_CHECKSUM_EN
   logic [31:0]        sum;

   // copier side
   modport master (
      input  start, src, dst, count, bus_gnt, bus_data_r,
      output busy, done, bus_req, bus_addr, bus_data_w, bus_mask_w, sum
   );
   // controller / memory side
   modport slave (
      output start, src, dst, count, bus_gnt, bus_data_r,
      input  busy, done, bus_req, bus_addr, bus_data_w, bus_mask_w, sum
   );
`else
   // copier side
   modport master (
      input  start, src, dst, count, bus_gnt, bus_data_r,
      output busy, done, bus_req, bus_addr, bus_data_w, bus_mask_w
   );
   // controller / memory side
   modport slave (
      output start, src, dst, count, bus_gnt, bus_data_r,
      input  busy, done, bus_req, bus_addr, bus_data_w, bus_mask_w
   );
`endif
endinterface

// File: rtl/bus_copier.sv
// bus_copier: word-granular memory-to-memory copy engine, second initiator on the CPU word bus.
// Latency: 3 cycles per word with grant held; done pulses 3N+1 cycles after start (1 for count=0).
// Backpressure: grant low stalls READ/WRITE by one cycle each; grant lost in LATCH restarts the read.
// Optional feature macro: BUS_COPIER_CHECKSUM_EN (running 32-bit sum of copied words on sum).
module bus_copier #(
   parameter int COUNT_W = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   bus_copier_if.master  io_cpy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_LATCH,
      ST_WRITE,
      ST_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [29:0]        r_src_ptr;
   logic [29:0]        r_dst_ptr;
   logic [COUNT_W-1:0] r_remaining;
   logic [31:0]        r_data;
   // last driven bus values, so address/data hold steady while idle
   logic [29:0]        r_last_addr;
   logic [31:0]        r_last_data;

   logic               w_accept;
   logic               w_capture;
   logic               w_wr_fire;
   logic [29:0]        w_addr;
   logic [31:0]        w_data_w;

   // state register; reset aborts any copy in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state decode and per-state bus drive
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_wr_fire   = 1'b0;
      w_addr      = r_last_addr;
      w_data_w    = r_last_data;
      case (r_state)
         ST_IDLE: begin
            if (io_cpy.start) begin
               w_accept    = 1'b1;
               w_state_nxt = (io_cpy.count != '0) ? ST_READ : ST_DONE;
            end
         end
         ST_READ: begin
            w_addr = r_src_ptr;
            if (io_cpy.bus_gnt) begin
               w_state_nxt = ST_LATCH;
            end
         end
         ST_LATCH: begin
            // read data is only trustworthy if we still own the bus
            w_addr = r_src_ptr;
            if (io_cpy.bus_gnt) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_WRITE;
            end else begin
               w_state_nxt = ST_READ;
            end
         end
         ST_WRITE: begin
            w_addr   = r_dst_ptr;
            w_data_w = r_data;
            if (io_cpy.bus_gnt) begin
               w_wr_fire   = 1'b1;
               w_state_nxt = (r_remaining == COUNT_W'(1)) ? ST_DONE : ST_READ;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // pointers, word counter, data holding register and held bus values
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_src_ptr   <= '0;
         r_dst_ptr   <= '0;
         r_remaining <= '0;
         r_data      <= '0;
         r_last_addr <= '0;
         r_last_data <= '0;
      end else begin
         r_last_addr <= w_addr;
         r_last_data <= w_data_w;
         if (w_accept) begin
            r_src_ptr   <= io_cpy.src;
            r_dst_ptr   <= io_cpy.dst;
            r_remaining <= io_cpy.count;
         end
         if (w_capture) begin
            r_data <= io_cpy.bus_data_r;
         end
         if (w_wr_fire) begin
            // 30-bit pointers wrap naturally at the top of the word space
            r_src_ptr <= r_src_ptr + 30'd1;
            r_dst_ptr <= r_dst_ptr + 30'd1;
            if (r_remaining != '0) begin
               r_remaining <= r_remaining - COUNT_W'(1);
            end
         end
      end
   end

`ifdef BUS_COPIER_CHECKSUM_EN
   logic [31:0] r_sum;

   // running sum of every word actually written; restarts with each command
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sum <= '0;
      end else if (w_accept) begin
         r_sum <= '0;
      end else if (w_wr_fire) begin
         r_sum <= r_sum + r_data;
      end
   end

   assign io_cpy.sum = r_sum;
`endif

   assign io_cpy.busy       = (r_state != ST_IDLE);
   assign io_cpy.done       = (r_state == ST_DONE);
   assign io_cpy.bus_req    = (r_state == ST_READ) || (r_state == ST_LATCH) || (r_state == ST_WRITE);
   assign io_cpy.bus_addr   = w_addr;
   assign io_cpy.bus_data_w = w_data_w;
   assign io_cpy.bus_mask_w = w_wr_fire ? 4'hF : 4'h0;

endmodule

// File: doc/bus_copier.md
# bus_copier

Word-granular memory-to-memory copy engine that acts as a second initiator on the CPU's 30-bit word-address memory bus (bus_addr / bus_data_r / bus_data_w / bus_mask_w). It reads a source word, writes it to the destination address, and advances. The bus is shared with the CPU and arbitrated externally through a request/grant pair. Typical uses: loading program images, relocating data and clearing buffers in block RAM without CPU instructions.

## Interface
- COUNT_W, 16, width of the word-count field; maximum transfer is 2^COUNT_W-1 words.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low (0 = reset).
- start  input  1  one-cycle command strobe; sampled only in IDLE.
- src  input  30  source word address.
- dst  input  30  destination word address.
- count  input  COUNT_W  number of words to copy.
- busy  output  1  high while a command is in progress (every state except IDLE).
- done  output  1  one-cycle completion pulse.
- bus_req  output  1  bus request; high in READ, LATCH and WRITE.
- bus_gnt  input  1  bus grant from the external arbiter/mux.
- bus_addr  output  30  word address.
- bus_data_r  input  32  read data; valid in the cycle after the address is presented.
- bus_data_w  output  32  write data.
- bus_mask_w  output  4  byte write enables; 4'hF on a granted write, otherwise 0.

## Operation
States: IDLE, READ, LATCH, WRITE, DONE.
- **IDLE**
  - On start=1 with count≠0: latch src, dst and count into src_ptr, dst_ptr and remaining, then go to READ.
  - On start=1 with count=0: go to DONE with no bus traffic.
- **READ**
  - bus_addr=src_ptr, bus_mask_w=0.
  - Go to LATCH if bus_gnt, else stay.
- **LATCH**
  - bus_addr=src_ptr.
  - If bus_gnt: capture bus_data_r into data_reg, then go to WRITE.
  - Else: return to READ and re-issue the read.
- **WRITE**
  - bus_addr=dst_ptr, bus_data_w=data_reg, bus_mask_w = bus_gnt ? 4'hF : 4'h0.
  - If bus_gnt: src_ptr+1, dst_ptr+1, remaining-1, then go to DONE if remaining was 1, else READ.
  - Else: hold.
- **DONE**
  - done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored; no queueing.
- Pointers wrap modulo 2^30 (0x3FFFFFFF+1 = 0). The remaining counter never underflows.
- Overlapping regions are copied strictly forward, word by word. No overlap detection.
- In IDLE and DONE, bus_addr and bus_data_w hold their last values and bus_mask_w=0.

## Timing
- Reset values: busy=0, done=0, bus_req=0, bus_mask_w=0, bus_addr=0, bus_data_w=0; state IDLE.
- Reset asserted mid-operation aborts immediately and asynchronously. A partially completed copy is not resumed.
- start is accepted at rising edge E0; busy is high from the cycle after E0.
- With bus_gnt constantly 1:
  - each word takes 3 cycles;
  - done is high in cycle 3N+1 after E0;
  - busy falls together with done.
- With count=0: done is high in cycle 1 after E0.
- Each grant-low cycle in READ or WRITE adds 1 cycle. A grant-low cycle in LATCH adds 2 cycles (the read restarts).
- A new start is accepted one cycle after done, at the earliest.

## Configuration
- Macro: BUS_COPIER_CHECKSUM_EN.
- **Defined:**
  - extra output port sum (32 bits), reset to 0;
  - cleared at each accepted start;
  - on every granted WRITE cycle, data_reg is added modulo 2^32;
  - sum is stable and final while done=1.
- **Undefined:** the port and the adder are absent; all other behaviour is identical.

## Test plan
- Copy with constant grant: mem[0x10..0x13]=1,2,3,4; src=0x10, dst=0x20, count=4, bus_gnt=1 → mem[0x20..0x23]=1,2,3,4, done high in cycle 13 after E0, exactly 4 cycles with bus_mask_w=4'hF.
- Zero count: count=0 → done in cycle 1 after E0, bus_req and bus_mask_w never nonzero.
- Grant stall:
  - stimulus: bus_gnt low for 5 cycles during the second WRITE (4-word copy);
  - response: bus_mask_w=0 throughout the stall, data correct, done in cycle 18 after E0.
- Reset mid-copy: reset low during LATCH of word 3 of 8 → all outputs zero at once, later 2-word copy completes correctly.
- Address wrap: src=0x3FFFFFFF, dst=0x100, count=2 → reads at 0x3FFFFFFF then 0x00000000, writes at 0x100 then 0x101.
- Checksum (BUS_COPIER_CHECKSUM_EN): source words 1, 2, 0xFFFFFFFF → sum=0x00000002 at done. A second start clears sum.
